// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold / shift right / shift left / parallel load,
// synchronous set, clock enable, optional rotate and a word-completion shift counter.
// Optional parity output is enabled by defining UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg #(
  parameter int WIDTH  = 8,
  parameter bit ROTATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             word_done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    shift_cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             shift_ev;
  logic             fill_msb;
  logic             fill_lsb;

  // With ROTATE set the serial inputs never reach the datapath, so X on them cannot leak.
  assign fill_msb = ROTATE ? q[0]       : sin_msb;
  assign fill_lsb = ROTATE ? q[WIDTH-1] : sin_lsb;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    q_nxt    = q;
    cnt_nxt  = shift_cnt;
    done_nxt = 1'b0;
    shift_ev = 1'b0;
    if (set) begin
      q_nxt   = '1;
      cnt_nxt = '0;
    end else if (en) begin
      unique case (mode_e'(mode))
        MODE_HOLD: ;
        MODE_SHR: begin
          q_nxt    = {fill_msb, q[WIDTH-1:1]};
          shift_ev = 1'b1;
        end
        MODE_SHL: begin
          q_nxt    = {q[WIDTH-2:0], fill_lsb};
          shift_ev = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt   = d;
          cnt_nxt = '0;
        end
      endcase
    end
    // Direction is irrelevant to the count; a WIDTH-th shift wraps it and fires the pulse.
    if (shift_ev) begin
      if (shift_cnt == CNT_LAST) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt = shift_cnt + CNT_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q         <= '0;
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      q         <= q_nxt;
      shift_cnt <= cnt_nxt;
      word_done <= done_nxt;
    end
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  // Computed from q_nxt so parity lands on the same edge as the data it covers.
  always_ff @(posedge clk) begin
    if (!reset) parity <= 1'b0;
    else        parity <= ^q_nxt;
  end
`endif

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: a ROTATE=0 and a ROTATE=1 instance share
// stimulus; each vector tags which instance it checks and on which cycle.
module tb_univ_shift_reg;

  typedef struct {
    int         cyc;
    bit         rot;
    logic [7:0] q;
    logic       wd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, set, en, sin_msb, sin_lsb;
  logic [1:0] mode;
  logic [7:0] d;
  logic [7:0] q0, q1;
  logic       sr0, sl0, wd0, sr1, sl1, wd1;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic       par0, par1;
`endif

  exp_t sb[$];
  int   cyc_cnt  = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   par_chk  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  univ_shift_reg #(.WIDTH(8), .ROTATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .set(set), .en(en), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q0), .sout_r(sr0), .sout_l(sl0),
    .word_done(wd0)
`ifdef UNIV_SHIFT_REG_PARITY_EN
    , .parity(par0)
`endif
  );

  univ_shift_reg #(.WIDTH(8), .ROTATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .set(set), .en(en), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q1), .sout_r(sr1), .sout_l(sl1),
    .word_done(wd1)
`ifdef UNIV_SHIFT_REG_PARITY_EN
    , .parity(par1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_cnt, act, exp);
    end
  endtask

  // Inputs are already set; queue the expectation for the coming edge and cross it.
  task automatic tick(input bit rot, input logic [7:0] eq, input logic ewd);
    exp_t e;
    e.cyc = cyc_cnt + 1;
    e.rot = rot;
    e.q   = eq;
    e.wd  = ewd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from input changes and the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = sb.pop_front();
      check("vector_cycle", 64'(cyc_cnt), 64'(e.cyc));
      if (!e.rot) begin
        check("q_rot0", 64'(q0), 64'(e.q));
        check("word_done_rot0", 64'(wd0), 64'(e.wd));
        check("sout_r_rot0", 64'(sr0), 64'(e.q[0]));
        check("sout_l_rot0", 64'(sl0), 64'(e.q[7]));
      end else begin
        check("q_rot1", 64'(q1), 64'(e.q));
        check("word_done_rot1", 64'(wd1), 64'(e.wd));
        check("sout_r_rot1", 64'(sr1), 64'(e.q[0]));
        check("sout_l_rot1", 64'(sl1), 64'(e.q[7]));
      end
    end
`ifdef UNIV_SHIFT_REG_PARITY_EN
    if (par_chk) begin
      check("parity_rot0", 64'(par0), 64'(^q0));
      check("parity_rot1", 64'(par1), 64'(^q1));
    end
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; set = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00;
    sin_msb = 1'b0; sin_lsb = 1'b0;
    @(posedge clk);
    #1;

    // Reset dominates set and load.
    reset = 1'b0; set = 1'b1; en = 1'b1; mode = 2'b11; d = 8'hA5;
    tick(0, 8'h00, 1'b0);
    par_chk = 1'b1;
    tick(0, 8'h00, 1'b0);
    tick(1, 8'h00, 1'b0);

    // Set, load, hold.
    reset = 1'b1;
    tick(0, 8'hFF, 1'b0);
    set = 1'b0; mode = 2'b11; d = 8'h3C;
    tick(0, 8'h3C, 1'b0);
    mode = 2'b00; d = 8'h55;
    repeat (3) tick(0, 8'h3C, 1'b0);

    // Serial fill, ROTATE=0.
    mode = 2'b11; d = 8'h81;
    tick(0, 8'h81, 1'b0);
    mode = 2'b01; sin_msb = 1'b1;
    tick(0, 8'hC0, 1'b0);
    mode = 2'b10; sin_lsb = 1'b0;
    tick(0, 8'h80, 1'b0);

    // Word counting across an enable gap, then a back-to-back second word.
    mode = 2'b11; d = 8'h00;
    tick(0, 8'h00, 1'b0);
    mode = 2'b10; sin_lsb = 1'b1;
    tick(0, 8'h01, 1'b0);
    tick(0, 8'h03, 1'b0);
    tick(0, 8'h07, 1'b0);
    tick(0, 8'h0F, 1'b0);
    en = 1'b0;
    repeat (2) tick(0, 8'h0F, 1'b0);
    en = 1'b1;
    tick(0, 8'h1F, 1'b0);
    tick(0, 8'h3F, 1'b0);
    tick(0, 8'h7F, 1'b0);
    tick(0, 8'hFF, 1'b1);
    sin_lsb = 1'b0;
    tick(0, 8'hFE, 1'b0);
    tick(0, 8'hFC, 1'b0);
    tick(0, 8'hF8, 1'b0);
    tick(0, 8'hF0, 1'b0);
    tick(0, 8'hE0, 1'b0);
    tick(0, 8'hC0, 1'b0);
    tick(0, 8'h80, 1'b0);
    tick(0, 8'h00, 1'b1);

    // Rotate instance: serial inputs ignored, full rotated word pulses.
    mode = 2'b11; d = 8'h81;
    tick(1, 8'h81, 1'b0);
    mode = 2'b10; sin_lsb = 1'b0;
    tick(1, 8'h03, 1'b0);
    mode = 2'b11; d = 8'h81;
    tick(1, 8'h81, 1'b0);
    mode = 2'b01; sin_msb = 1'b0;
    tick(1, 8'hC0, 1'b0);
    tick(1, 8'h60, 1'b0);
    sin_msb = 1'b1;
    tick(1, 8'h30, 1'b0);
    mode = 2'b10; sin_lsb = 1'b1;
    tick(1, 8'h60, 1'b0);
    sin_lsb = 1'b0;
    tick(1, 8'hC0, 1'b0);
    sin_lsb = 1'b1;
    tick(1, 8'h81, 1'b0);
    tick(1, 8'h03, 1'b0);
    tick(1, 8'h06, 1'b1);

    // Mid-word reset discards the partial count.
    mode = 2'b11; d = 8'h00;
    tick(0, 8'h00, 1'b0);
    mode = 2'b10; sin_lsb = 1'b1;
    tick(0, 8'h01, 1'b0);
    tick(0, 8'h03, 1'b0);
    tick(0, 8'h07, 1'b0);
    tick(0, 8'h0F, 1'b0);
    tick(0, 8'h1F, 1'b0);
    reset = 1'b0;
    tick(0, 8'h00, 1'b0);
    reset = 1'b1;
    tick(0, 8'h01, 1'b0);
    tick(0, 8'h03, 1'b0);
    tick(0, 8'h07, 1'b0);
    tick(0, 8'h0F, 1'b0);
    tick(0, 8'h1F, 1'b0);
    tick(0, 8'h3F, 1'b0);
    tick(0, 8'h7F, 1'b0);
    tick(0, 8'hFF, 1'b1);

    // Mid-word set does the same and forces all-ones.
    sin_lsb = 1'b0;
    tick(0, 8'hFE, 1'b0);
    tick(0, 8'hFC, 1'b0);
    tick(0, 8'hF8, 1'b0);
    tick(0, 8'hF0, 1'b0);
    tick(0, 8'hE0, 1'b0);
    set = 1'b1;
    tick(0, 8'hFF, 1'b0);
    set = 1'b0;
    tick(0, 8'hFE, 1'b0);
    tick(0, 8'hFC, 1'b0);
    tick(0, 8'hF8, 1'b0);
    tick(0, 8'hF0, 1'b0);
    tick(0, 8'hE0, 1'b0);
    tick(0, 8'hC0, 1'b0);
    tick(0, 8'h80, 1'b0);
    tick(0, 8'h00, 1'b1);
    mode = 2'b00;
    tick(0, 8'h00, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
